// File: rtl/execute_pkg.sv
// Shared definitions for the EX stage: opcodes, IR field positions and FSM states.
package execute_pkg;

  localparam logic [5:0] OPC_NOP  = 6'b000000;
  localparam logic [5:0] OPC_ADD  = 6'b000001;
  localparam logic [5:0] OPC_SUB  = 6'b000010;
  localparam logic [5:0] OPC_AND  = 6'b000011;
  localparam logic [5:0] OPC_OR   = 6'b000100;
  localparam logic [5:0] OPC_XOR  = 6'b000101;
  localparam logic [5:0] OPC_SLT  = 6'b000110;
  localparam logic [5:0] OPC_MUL  = 6'b000111;
  localparam logic [5:0] OPC_LW   = 6'b001000;
  localparam logic [5:0] OPC_SW   = 6'b001001;
  localparam logic [5:0] OPC_BEQZ = 6'b001010;
  localparam logic [5:0] OPC_J    = 6'b001011;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int JOFF_HI = 25;
  localparam int JOFF_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } ex_state_e;

endpackage

// File: rtl/execute_if.sv
// ID/EX -> EX -> EX/MEM pipeline bundle; master is the surrounding pipeline, slave is the EX stage.
interface execute_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       ID_EX_IR;
  logic [DATA_W-1:0] ID_EX_NPC;
  logic [DATA_W-1:0] ID_EX_A;
  logic [DATA_W-1:0] ID_EX_B;
  logic [DATA_W-1:0] ID_EX_Imm;
  logic              ID_EX_valid;
  logic              mem_stall;
  logic              ex_flush;
  logic              ex_busy;
  logic [31:0]       EX_MEM_IR;
  logic [DATA_W-1:0] EX_MEM_NPC;
  logic [DATA_W-1:0] EX_MEM_ALUo;
  logic [DATA_W-1:0] EX_MEM_B;
  logic              EX_MEM_cond;
  logic              EX_MEM_valid;

  modport master (
    output ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_Imm, ID_EX_valid,
    output mem_stall, ex_flush,
    input  ex_busy,
    input  EX_MEM_IR, EX_MEM_NPC, EX_MEM_ALUo, EX_MEM_B, EX_MEM_cond, EX_MEM_valid
  );

  modport slave (
    input  ID_EX_IR, ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_Imm, ID_EX_valid,
    input  mem_stall, ex_flush,
    output ex_busy,
    output EX_MEM_IR, EX_MEM_NPC, EX_MEM_ALUo, EX_MEM_B, EX_MEM_cond, EX_MEM_valid
  );
endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per enabled cycle.
// prod_next_o is the accumulator after the step in progress, so the final result is usable on that same edge.
module ex_mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] prod_next_o,
  output logic [DATA_W-1:0] prod_o
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]  cnt_q;

  assign prod_next_o = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_o      = acc_q;
  // Asserted while the final iteration is the one being performed.
  assign done_o      = (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= prod_next_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/execute.sv
// EX stage: single-cycle ALU/address/branch ops plus a multi-cycle MUL that stalls the front end.
module execute
  import execute_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      rst,
  execute_if.slave pipe
);
  ex_state_e         state_q, state_d;
  logic [31:0]       ir_q, ir_d, mul_ir_q;
  logic [DATA_W-1:0] npc_q, npc_d, alu_q, alu_d, b_q, b_d, mul_npc_q, mul_b_q;
  logic              cond_q, cond_d, valid_q, valid_d;
  logic [5:0]        opcode;
  logic              is_mul, alu_cond;
  logic [DATA_W-1:0] alu_res, mul_prod_next, mul_prod;
  logic              mul_start, mul_step, mul_done;

  assign opcode = pipe.ID_EX_IR[OPC_HI:OPC_LO];
  assign is_mul = MUL_EN && (opcode == OPC_MUL);

  always_comb begin
    alu_res  = '0;
    alu_cond = 1'b0;
    case (opcode)
      OPC_NOP:        alu_res = '0;
      OPC_ADD:        alu_res = pipe.ID_EX_A + pipe.ID_EX_B;
      OPC_SUB:        alu_res = pipe.ID_EX_A - pipe.ID_EX_B;
      OPC_AND:        alu_res = pipe.ID_EX_A & pipe.ID_EX_B;
      OPC_OR:         alu_res = pipe.ID_EX_A | pipe.ID_EX_B;
      OPC_XOR:        alu_res = pipe.ID_EX_A ^ pipe.ID_EX_B;
      OPC_SLT:        alu_res = DATA_W'($signed(pipe.ID_EX_A) < $signed(pipe.ID_EX_B));
      OPC_LW, OPC_SW: alu_res = pipe.ID_EX_A + pipe.ID_EX_Imm;
      OPC_BEQZ: begin
        alu_res  = pipe.ID_EX_NPC + (pipe.ID_EX_Imm << 2);
        alu_cond = (pipe.ID_EX_A == '0);
      end
      OPC_J: begin
        alu_res  = DATA_W'({pipe.ID_EX_NPC[DATA_W-1 -: 4], pipe.ID_EX_IR[JOFF_HI:JOFF_LO], 2'b00});
        alu_cond = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    npc_d     = npc_q;
    alu_d     = alu_q;
    b_d       = b_q;
    cond_d    = cond_q;
    valid_d   = valid_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    if (pipe.ex_flush) begin
      state_d = ST_IDLE;
      if (!pipe.mem_stall) valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!pipe.mem_stall) begin
            if (pipe.ID_EX_valid && is_mul) begin
              mul_start = 1'b1;
              state_d   = ST_MUL;
              valid_d   = 1'b0;
            end else if (pipe.ID_EX_valid) begin
              ir_d    = pipe.ID_EX_IR;
              npc_d   = pipe.ID_EX_NPC;
              alu_d   = alu_res;
              b_d     = pipe.ID_EX_B;
              cond_d  = alu_cond;
              valid_d = 1'b1;
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        ST_MUL: begin
          // Iterations keep running under mem_stall; only the write-back waits.
          mul_step = 1'b1;
          if (mul_done) begin
            if (!pipe.mem_stall) begin
              ir_d    = mul_ir_q;
              npc_d   = mul_npc_q;
              alu_d   = mul_prod_next;
              b_d     = mul_b_q;
              cond_d  = 1'b0;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!pipe.mem_stall) begin
            ir_d    = mul_ir_q;
            npc_d   = mul_npc_q;
            alu_d   = mul_prod;
            b_d     = mul_b_q;
            cond_d  = 1'b0;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      npc_q     <= '0;
      alu_q     <= '0;
      b_q       <= '0;
      cond_q    <= 1'b0;
      valid_q   <= 1'b0;
      mul_ir_q  <= '0;
      mul_npc_q <= '0;
      mul_b_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      alu_q   <= alu_d;
      b_q     <= b_d;
      cond_q  <= cond_d;
      valid_q <= valid_d;
      if (mul_start) begin
        mul_ir_q  <= pipe.ID_EX_IR;
        mul_npc_q <= pipe.ID_EX_NPC;
        mul_b_q   <= pipe.ID_EX_B;
      end
    end
  end

  ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk         (clk),
    .rst         (rst),
    .start_i     (mul_start),
    .step_i      (mul_step),
    .a_i         (pipe.ID_EX_A),
    .b_i         (pipe.ID_EX_B),
    .done_o      (mul_done),
    .prod_next_o (mul_prod_next),
    .prod_o      (mul_prod)
  );

  assign pipe.ex_busy      = (state_q != ST_IDLE) | pipe.mem_stall;
  assign pipe.EX_MEM_IR    = ir_q;
  assign pipe.EX_MEM_NPC   = npc_q;
  assign pipe.EX_MEM_ALUo  = alu_q;
  assign pipe.EX_MEM_B     = b_q;
  assign pipe.EX_MEM_cond  = cond_q;
  assign pipe.EX_MEM_valid = valid_q;
endmodule

// File: tb/tb_execute.sv
// Directed bench for the EX stage: ALU ops, branches, MUL latency, HOLD, flush and reset abort.
module tb_execute;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  execute_if #(.DATA_W(32)) bus ();

  execute #(.DATA_W(32), .MUL_EN(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] npc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    bus.ID_EX_IR    = ir;
    bus.ID_EX_NPC   = npc;
    bus.ID_EX_A     = a;
    bus.ID_EX_B     = b;
    bus.ID_EX_Imm   = imm;
    bus.ID_EX_valid = 1'b1;
  endtask

  task automatic single(input string tag, input logic [31:0] ir, input logic [31:0] npc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] exp_alu, input logic exp_cond);
    issue(ir, npc, a, b, imm);
    step();
    bus.ID_EX_valid = 1'b0;
    $display("txn %s ir=%h a=%h b=%h imm=%h -> aluo=%h cond=%0b", tag, ir, a, b, imm,
             bus.EX_MEM_ALUo, bus.EX_MEM_cond);
    chk({tag, "_aluo"}, bus.EX_MEM_ALUo, exp_alu);
    chk({tag, "_cond"}, 32'(bus.EX_MEM_cond), 32'(exp_cond));
    chk({tag, "_valid"}, 32'(bus.EX_MEM_valid), 32'd1);
    chk({tag, "_ir"}, bus.EX_MEM_IR, ir);
    chk({tag, "_b"}, bus.EX_MEM_B, b);
  endtask

  // Issues a MUL, checks the 31 busy/bubble cycles, then the result after edge T+32.
  task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int bad_busy = 0;
    int bad_valid = 0;
    issue(32'h1C000000, 32'h80, a, b, 32'h0);
    step();
    bus.ID_EX_valid = 1'b0;
    chk({tag, "_busy_T"}, 32'(bus.ex_busy), 32'd1);
    chk({tag, "_valid_T"}, 32'(bus.EX_MEM_valid), 32'd0);
    for (int i = 1; i <= 31; i++) begin
      step();
      if (bus.ex_busy !== 1'b1) bad_busy++;
      if (bus.EX_MEM_valid !== 1'b0) bad_valid++;
    end
    chk({tag, "_busy_cycles_bad"}, 32'(bad_busy), 32'd0);
    chk({tag, "_early_valid_bad"}, 32'(bad_valid), 32'd0);
    step();
    $display("txn %s a=%h b=%h -> aluo=%h valid=%0b", tag, a, b, bus.EX_MEM_ALUo, bus.EX_MEM_valid);
    chk({tag, "_aluo"}, bus.EX_MEM_ALUo, exp);
    chk({tag, "_valid"}, 32'(bus.EX_MEM_valid), 32'd1);
    chk({tag, "_busy_after"}, 32'(bus.ex_busy), 32'd0);
    chk({tag, "_ir"}, bus.EX_MEM_IR, 32'h1C000000);
    chk({tag, "_cond"}, 32'(bus.EX_MEM_cond), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.ID_EX_IR = '0; bus.ID_EX_NPC = '0; bus.ID_EX_A = '0; bus.ID_EX_B = '0;
    bus.ID_EX_Imm = '0; bus.ID_EX_valid = 1'b0; bus.mem_stall = 1'b0; bus.ex_flush = 1'b0;
    step();
    step();
    $display("txn reset");
    chk("rst_ir", bus.EX_MEM_IR, 32'h0);
    chk("rst_aluo", bus.EX_MEM_ALUo, 32'h0);
    chk("rst_npc", bus.EX_MEM_NPC, 32'h0);
    chk("rst_valid", 32'(bus.EX_MEM_valid), 32'd0);
    chk("rst_busy", 32'(bus.ex_busy), 32'd0);
    rst = 1'b0;

    single("add", 32'h04221800, 32'h4, 32'd7, 32'd15, 32'h0, 32'd22, 1'b0);
    chk("add_busy", 32'(bus.ex_busy), 32'd0);
    single("lw", 32'h20000000, 32'h8, 32'h100, 32'd9, 32'd4, 32'h104, 1'b0);
    single("sw", 32'h24000000, 32'hC, 32'h100, 32'd9, 32'd4, 32'h104, 1'b0);
    single("beqz_t", 32'h28000000, 32'h20, 32'h0, 32'h0, 32'd3, 32'h2C, 1'b1);
    single("beqz_nt", 32'h28000000, 32'h20, 32'd5, 32'h0, 32'd3, 32'h2C, 1'b0);
    single("j", 32'h2C000004, 32'h40, 32'h0, 32'h0, 32'h0, 32'h10, 1'b1);
    single("sub", 32'h08000000, 32'h4, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFE, 1'b0);
    single("slt", 32'h18000000, 32'h4, 32'hFFFFFFFF, 32'd1, 32'h0, 32'd1, 1'b0);
    single("xor", 32'h14000000, 32'h4, 32'hF0F0, 32'hFF00, 32'h0, 32'h0FF0, 1'b0);
    single("unk", 32'hFC000000, 32'h4, 32'd3, 32'd4, 32'h0, 32'h0, 1'b0);

    step();
    $display("txn bubble");
    chk("bubble_valid", 32'(bus.EX_MEM_valid), 32'd0);

    // A single-cycle op offered under mem_stall is not accepted.
    single("add2", 32'h04000000, 32'h4, 32'd1, 32'd1, 32'h0, 32'd2, 1'b0);
    bus.mem_stall = 1'b1;
    issue(32'h04000000, 32'h4, 32'd10, 32'd10, 32'h0);
    #1;
    chk("stall_busy", 32'(bus.ex_busy), 32'd1);
    step();
    $display("txn stalled add");
    chk("stall_aluo_held", bus.EX_MEM_ALUo, 32'd2);
    chk("stall_valid_held", 32'(bus.EX_MEM_valid), 32'd1);
    bus.mem_stall = 1'b0;
    bus.ID_EX_valid = 1'b0;
    step();

    mul_run("mul_6x7", 32'd6, 32'd7, 32'd42);
    mul_run("mul_neg", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);

    // MUL completing under mem_stall parks in HOLD.
    issue(32'h1C000000, 32'h80, 32'd6, 32'd7, 32'h0);
    step();
    bus.ID_EX_valid = 1'b0;
    for (int i = 1; i <= 29; i++) step();
    bus.mem_stall = 1'b1;
    for (int i = 30; i <= 35; i++) step();
    $display("txn mul hold");
    chk("hold_valid", 32'(bus.EX_MEM_valid), 32'd0);
    bus.mem_stall = 1'b0;
    #1;
    chk("hold_busy", 32'(bus.ex_busy), 32'd1);
    step();
    chk("hold_aluo", bus.EX_MEM_ALUo, 32'd42);
    chk("hold_valid_out", 32'(bus.EX_MEM_valid), 32'd1);
    chk("hold_busy_after", 32'(bus.ex_busy), 32'd0);

    // Flush at T+10 aborts the MUL; the next op is accepted immediately.
    issue(32'h1C000000, 32'h80, 32'd6, 32'd7, 32'h0);
    step();
    bus.ID_EX_valid = 1'b0;
    for (int i = 1; i <= 9; i++) step();
    bus.ex_flush = 1'b1;
    step();
    bus.ex_flush = 1'b0;
    $display("txn mul flush");
    chk("flush_busy", 32'(bus.ex_busy), 32'd0);
    chk("flush_valid", 32'(bus.EX_MEM_valid), 32'd0);
    single("post_flush_add", 32'h04000000, 32'h4, 32'd1, 32'd2, 32'h0, 32'd3, 1'b0);
    begin
      int stray = 0;
      for (int i = 0; i < 30; i++) begin
        step();
        if (bus.EX_MEM_valid !== 1'b0) stray++;
      end
      chk("flush_no_result", 32'(stray), 32'd0);
    end

    // Reset at T+5 of a MUL.
    issue(32'h1C000000, 32'h80, 32'd6, 32'd7, 32'h0);
    step();
    bus.ID_EX_valid = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    rst = 1'b1;
    step();
    $display("txn mul reset");
    chk("mrst_busy", 32'(bus.ex_busy), 32'd0);
    chk("mrst_ir", bus.EX_MEM_IR, 32'h0);
    chk("mrst_npc", bus.EX_MEM_NPC, 32'h0);
    chk("mrst_aluo", bus.EX_MEM_ALUo, 32'h0);
    chk("mrst_b", bus.EX_MEM_B, 32'h0);
    chk("mrst_cond", 32'(bus.EX_MEM_cond), 32'd0);
    chk("mrst_valid", 32'(bus.EX_MEM_valid), 32'd0);
    rst = 1'b0;
    single("post_rst_add", 32'h04000000, 32'h4, 32'd20, 32'd22, 32'h0, 32'd42, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute.md
Name: execute

Overview:
- EX stage of the five-stage PIPE integer pipeline. Sits directly downstream of decode.
- Consumes the ID/EX latch (IR, NPC, A, B, Imm) and performs ALU, address, branch and jump computation.
- Registers results into the EX/MEM latch for the memory stage.
- Contains an iterative shift-add multiplier. While the multiplier runs, the stage stalls the front end through ex_busy.

Parameters:
- DATA_W, 32, datapath width; all data ports are this width.
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL is treated as an unknown opcode.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ID_EX_IR  input  32  instruction word from decode.
- ID_EX_NPC  input  32  PC+4 of that instruction.
- ID_EX_A  input  32  rs operand.
- ID_EX_B  input  32  rt operand.
- ID_EX_Imm  input  32  sign-extended IR[15:0].
- ID_EX_valid  input  1  ID/EX latch holds a live instruction.
- mem_stall  input  1  memory stage cannot accept; the EX/MEM latch must hold.
- ex_flush  input  1  squash: the incoming instruction and any in-flight MUL are discarded.
- ex_busy  output  1  upstream must hold the ID/EX latch this cycle.
- EX_MEM_IR  output  32  instruction passed down.
- EX_MEM_NPC  output  32  NPC passed down.
- EX_MEM_ALUo  output  32  ALU result, effective address, or branch/jump target.
- EX_MEM_B  output  32  store data (B passed through).
- EX_MEM_cond  output  1  1 = branch/jump taken.
- EX_MEM_valid  output  1  EX/MEM latch holds a live instruction.

Behaviour:
- Reset: every EX_MEM_* output is 0, the FSM is in IDLE, and the multiply counter and accumulator are 0. Reset overrides flush, stall and an in-flight MUL.
- Opcode is IR[31:26]. Results by opcode:
  - 000000 NOP: ALUo=0.
  - 000001 ADD: A+B.
  - 000010 SUB: A-B.
  - 000011 AND: A&B.
  - 000100 OR: A|B.
  - 000101 XOR: A^B.
  - 000110 SLT: 1 if signed A<B, else 0.
  - 000111 MUL: low 32 bits of A*B.
  - 001000 LW and 001001 SW: A+Imm.
  - 001010 BEQZ: ALUo = NPC+(Imm<<2); cond = (A==0).
  - 001011 J: ALUo = {NPC[31:28], IR[25:0], 2'b00}; cond=1.
  - Any other opcode: ALUo=0, cond=0; IR/NPC/B still pass down with valid.
- All arithmetic is modulo 2^32 with no overflow trap. cond=0 for every non-branch/jump opcode.
- IR, NPC and B are copied unchanged into the EX/MEM latch.
- FSM states: IDLE, MUL, HOLD. ex_busy = (state!=IDLE) | mem_stall.
- IDLE, single-cycle op: an instruction is accepted at an edge where ID_EX_valid=1, mem_stall=0 and ex_flush=0. Its result appears in EX/MEM after that same edge (latency 1). If ID_EX_valid=0, a bubble is loaded (EX_MEM_valid=0).
- IDLE, MUL accepted at edge T:
  - Capture multiplicand = A, multiplier = B, accumulator = 0, counter = 0, IR and NPC.
  - Go to MUL; EX_MEM_valid<=0, provided mem_stall is 0.
- MUL state, each edge:
  - If multiplier[0]=1, accumulator += multiplicand.
  - Multiplicand <<= 1; multiplier >>= 1; counter++.
  - The 32nd iteration completes at edge T+32. If mem_stall=0 at that edge, the result is written to EX/MEM with valid=1 and the FSM returns to IDLE. Otherwise the FSM goes to HOLD.
  - Iterations continue regardless of mem_stall.
- HOLD: the result is written at the first edge with mem_stall=0, then the FSM goes to IDLE.
- mem_stall=1: the EX/MEM latch holds all fields and no instruction is accepted.
- ex_flush=1:
  - The incoming instruction is dropped.
  - The FSM goes to IDLE, aborting MUL/HOLD; the partial product is discarded.
  - EX_MEM_valid<=0 if mem_stall=0; otherwise the EX/MEM latch holds, since it contains an older instruction.
- Priority: rst > ex_flush > mem_stall > normal operation.

Decomposition:
- Package execute_pkg holds:
  - opcode constants OPC_NOP … OPC_J;
  - FSM state typedef;
  - field-slice constants for opcode [31:26] and jump offset [25:0].
- One sub-module, ex_mul_iter: the shift-add multiplier datapath with start, done and counter. The execute FSM owns its control handshake.

Test Plan:
- ADD: IR=32'h04221800, A=7, B=15, valid=1 -> after 1 edge ALUo=22, cond=0, valid=1, ex_busy=0.
- LW/SW: IR opcode 001000, A=32'h100, Imm=4, B=9 -> ALUo=32'h104, EX_MEM_B=9. Repeat with SW (001001): same values.
- BEQZ/J:
  - BEQZ: A=0, NPC=32'h20, Imm=3 -> ALUo=32'h2C, cond=1. With A=5: cond=0.
  - J: IR=32'h2C000004, NPC=32'h40 -> ALUo=32'h10, cond=1.
- MUL: A=6, B=7 accepted at edge T -> ex_busy=1 for 32 cycles, EX_MEM_valid=0 through T+31, ALUo=42 with valid=1 after T+32. Also A=32'hFFFFFFFF, B=2 -> 32'hFFFFFFFE.
- MUL with mem_stall=1 over T+30..T+35 -> FSM in HOLD, EX/MEM holds the prior instruction, result 42 written on the first edge with mem_stall=0.
- Abort: ex_flush at T+10 of a MUL -> IDLE next edge, no result emitted, ex_busy=0. rst at T+5 -> all outputs 0, state IDLE.
